// File: rtl/mac_tx_pkg.sv
// Shared FSM encoding, requester indices and round-robin helper for the
// MAC transmit scheduler.
package mac_tx_pkg;

    localparam int NREQ = 3;

    localparam logic [1:0] REQ_ARP  = 2'd0;
    localparam logic [1:0] REQ_ICMP = 2'd1;
    localparam logic [1:0] REQ_UDP  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_e;

    // Next requester index in round-robin order, wrapping UDP back to ARP.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= REQ_UDP) ? REQ_ARP : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin pick: searches upward from (last + 1) mod 3
// and returns a one-hot grant plus the winner index.
module rr_arb3
    import mac_tx_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      idx
);

    logic [1:0] c0, c1, c2;

    assign c0 = rr_next(last);
    assign c1 = rr_next(c0);
    assign c2 = rr_next(c1);

    function automatic logic req_at(input logic [NREQ-1:0] r, input logic [1:0] i);
        case (i)
            REQ_ARP:  return r[0];
            REQ_ICMP: return r[1];
            default:  return r[2];
        endcase
    endfunction

    always_comb begin
        idx = c0;
        if (req_at(req, c0)) begin
            idx = c0;
        end else if (req_at(req, c1)) begin
            idx = c1;
        end else if (req_at(req, c2)) begin
            idx = c2;
        end
        grant = '0;
        if (|req) begin
            case (idx)
                REQ_ARP:  grant = 3'b001;
                REQ_ICMP: grant = 3'b010;
                default:  grant = 3'b100;
            endcase
        end
    end

endmodule

// File: rtl/mac_tx_sched.sv
// MAC transmit scheduler: arbitrates ARP/ICMP/UDP frame requests, hands the
// winner's header fields to the packer and enforces the inter-frame gap.
// Optional watchdog abort is built when MAC_TX_SCHED_WDOG_EN is defined.
module mac_tx_sched
    import mac_tx_pkg::*;
#(
    parameter int IFG_CYCLES  = 12,
    parameter int WDOG_CYCLES = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [48*NREQ-1:0]   req_des_mac,
    input  logic [16*NREQ-1:0]   req_prot_type,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 pack_fifo_empty,
    output logic [47:0]          des_mac_addr,
    output logic [15:0]          prot_type,
    input  logic                 mac_head_end,
    input  logic                 tx_busy,
    output logic                 sched_err
);

    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

    state_e          state_q, state_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [1:0]      last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [47:0]     mac_q, mac_d;
    logic [15:0]     prot_q, prot_d;
    logic [NREQ-1:0] arb_gnt;
    logic [1:0]      arb_idx;
    logic            wdog_hit;

    rr_arb3 u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

`ifdef MAC_TX_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              in_wait;

    assign in_wait  = (state_q == ST_START) || (state_q == ST_WAIT_BUSY) ||
                      (state_q == ST_WAIT_DONE);
    assign wdog_hit = in_wait && (wdog_cnt_q == WDOG_LAST);

    // Counts only while waiting on the packer; any state change restarts it.
    always_comb begin
        wdog_cnt_d = '0;
        if (in_wait && (state_d == state_q)) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYCLES != 0);
    assign wdog_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            last_q    <= REQ_UDP;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            mac_q     <= '0;
            prot_q    <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mac_q     <= mac_d;
            prot_q    <= prot_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE:      if (|req) state_d = ST_ARB;
            ST_ARB:       state_d = (|arb_gnt) ? ST_START : ST_IDLE;
            ST_START:     if (mac_head_end) state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state_d = ST_GAP;
            ST_GAP: begin
                if (gap_cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
        if (wdog_hit) begin
            state_d = ST_GAP;
        end
        if (state_d != state_q) begin
            gap_cnt_d = '0;
        end
    end

    always_comb begin
        last_d = last_q;
        gnt_d  = gnt_q;
        done_d = '0;
        err_d  = 1'b0;
        mac_d  = mac_q;
        prot_d = prot_q;
        if ((state_q == ST_ARB) && (|arb_gnt)) begin
            last_d = arb_idx;
            gnt_d  = arb_gnt;
            case (arb_idx)
                REQ_ARP: begin
                    mac_d  = req_des_mac[47:0];
                    prot_d = req_prot_type[15:0];
                end
                REQ_ICMP: begin
                    mac_d  = req_des_mac[95:48];
                    prot_d = req_prot_type[31:16];
                end
                default: begin
                    mac_d  = req_des_mac[143:96];
                    prot_d = req_prot_type[47:32];
                end
            endcase
        end
        if ((state_q == ST_WAIT_DONE) && !tx_busy && !wdog_hit) begin
            done_d = gnt_q;
            gnt_d  = '0;
        end
        // Abort drops the grant silently; the requester sees no done.
        if (wdog_hit) begin
            gnt_d = '0;
            err_d = 1'b1;
        end
        pack_fifo_empty = (state_q != ST_START);
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign sched_err    = err_q;
    assign des_mac_addr = mac_q;
    assign prot_type    = prot_q;

endmodule
